// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback path.
// Optional macro WB_BYPASS_EN is consumed by writeback_unit, not here.
package wb_pkg;
   localparam int REG_IDX_W = 5;
   localparam int DEF_XLEN  = 32;
   localparam int DEF_DEPTH = 4;
   localparam int PTR_W     = (DEF_DEPTH > 1) ? $clog2(DEF_DEPTH) : 1;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [DEF_XLEN-1:0]  data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous DEPTH-entry FIFO holding returning load results.
// Occupancy comes from a count register; pointers wrap naturally.
module wb_fifo import wb_pkg::*; #(
   parameter int  DEPTH = DEF_DEPTH,
   parameter type T     = wb_entry_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  T     din,
   output logic full,
   output logic empty,
   output T     head
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T              mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          do_push, do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results onto the single register-file write port and
// tracks pending load destinations. Define WB_BYPASS_EN for forwarding outputs.
module writeback_unit import wb_pkg::*; #(
   parameter int XLEN  = DEF_XLEN,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alu_we,
   input  logic [REG_IDX_W-1:0] alu_rd,
   input  logic [XLEN-1:0]      alu_data,
   input  logic                 ld_issue,
   input  logic [REG_IDX_W-1:0] ld_issue_rd,
   output logic                 ld_issue_ok,
   input  logic                 ld_valid,
   output logic                 ld_ready,
   input  logic [REG_IDX_W-1:0] ld_rd,
   input  logic [XLEN-1:0]      ld_data,
   input  logic [REG_IDX_W-1:0] rs1,
   input  logic [REG_IDX_W-1:0] rs2,
   output logic                 hazard_rs1,
   output logic                 hazard_rs2,
   output logic                 wb_we,
   output logic [REG_IDX_W-1:0] wb_rd,
   output logic [XLEN-1:0]      wb_data
`ifdef WB_BYPASS_EN
   ,
   output logic                 fwd_rs1_hit,
   output logic                 fwd_rs2_hit,
   output logic [XLEN-1:0]      fwd_rs1_data,
   output logic [XLEN-1:0]      fwd_rs2_data
`endif
);
   localparam int NREG = 1 << REG_IDX_W;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } entry_t;

   entry_t          push_e, head;
   logic            full, empty, pop, alu_win;
   logic [NREG-1:0] pend, pend_set, pend_clr;

   assign push_e  = '{rd: ld_rd, data: ld_data};
   assign alu_win = alu_we && (alu_rd != '0);
   // ALU owns the port when it has a real write; the FIFO drains otherwise.
   assign pop     = !alu_win && !empty;

   wb_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ld_valid),
      .pop   (pop),
      .din   (push_e),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   assign ld_ready    = !full;
   assign ld_issue_ok = !pend[ld_issue_rd];
   assign hazard_rs1  = pend[rs1] && (rs1 != '0);
   assign hazard_rs2  = pend[rs2] && (rs2 != '0);

   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      if (ld_issue && ld_issue_ok && (ld_issue_rd != '0)) pend_set[ld_issue_rd] = 1'b1;
      if (pop && (head.rd != '0)) pend_clr[head.rd] = 1'b1;
   end

   // Set is ORed in after the clear so a same-cycle set wins.
   always_ff @(posedge clk) begin
      if (!rst_n) pend <= '0;
      else        pend <= (pend & ~pend_clr) | pend_set;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_we   <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else if (alu_win) begin
         wb_we   <= 1'b1;
         wb_rd   <= alu_rd;
         wb_data <= alu_data;
      end else if (pop) begin
         wb_we   <= (head.rd != '0);
         wb_rd   <= head.rd;
         wb_data <= head.data;
      end else begin
         wb_we   <= 1'b0;
      end
   end

`ifdef WB_BYPASS_EN
   assign fwd_rs1_hit  = wb_we && (wb_rd == rs1) && (rs1 != '0);
   assign fwd_rs2_hit  = wb_we && (wb_rd == rs2) && (rs2 != '0);
   assign fwd_rs1_data = wb_data;
   assign fwd_rs2_data = wb_data;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: queue-based reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_writeback_unit;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            alu_we = 0, ld_issue = 0, ld_valid = 0;
   logic [4:0]      alu_rd = 0, ld_issue_rd = 0, ld_rd = 0, rs1 = 0, rs2 = 0;
   logic [XLEN-1:0] alu_data = 0, ld_data = 0;
   logic            ld_issue_ok, ld_ready, hazard_rs1, hazard_rs2, wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
`ifdef WB_BYPASS_EN
   logic            fwd_rs1_hit, fwd_rs2_hit;
   logic [XLEN-1:0] fwd_rs1_data, fwd_rs2_data;
`endif

   writeback_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ok(ld_issue_ok),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .rs1(rs1), .rs2(rs2), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef WB_BYPASS_EN
      , .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
      .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data)
`endif
   );

   always #5 clk = ~clk;

   int asserts = 0;
   int fails   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of returned loads and a set of pending registers.
   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } ent_t;

   ent_t            mq[$];
   bit              mpend[32];
   logic            m_we = 0;
   logic [4:0]      m_rd = 0;
   logic [XLEN-1:0] m_data = 0;

   always @(posedge clk) begin : model
      ent_t h;
      bit   alu_ok, issue_ok, room;
      if (!rst_n) begin
         mq.delete();
         foreach (mpend[i]) mpend[i] = 1'b0;
         m_we = 0; m_rd = 0; m_data = 0;
      end else begin
         alu_ok   = alu_we && alu_rd != 0;
         issue_ok = !mpend[ld_issue_rd];
         room     = mq.size() < DEPTH;
         if (alu_ok && mpend[alu_rd]) begin
            fails++;
            $display("FAIL alu_to_pending: alu_rd=%0d is pending", alu_rd);
         end
         if (alu_ok) begin
            m_we = 1; m_rd = alu_rd; m_data = alu_data;
         end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_we = (h.rd != 0); m_rd = h.rd; m_data = h.data;
            if (h.rd != 0) mpend[h.rd] = 1'b0;
         end else begin
            m_we = 0;
         end
         if (ld_issue && issue_ok && ld_issue_rd != 0) mpend[ld_issue_rd] = 1'b1;
         if (ld_valid && room) mq.push_back('{ld_rd, ld_data});
      end
   end

   always @(posedge clk) begin : compare
      #2;
      chk("wb_we", wb_we, m_we);
      chk("wb_rd", wb_rd, m_rd);
      chk("wb_data", wb_data, m_data);
      chk("ld_ready", ld_ready, mq.size() < DEPTH);
      chk("ld_issue_ok", ld_issue_ok, !mpend[ld_issue_rd]);
      chk("hazard_rs1", hazard_rs1, mpend[rs1] && rs1 != 0);
      chk("hazard_rs2", hazard_rs2, mpend[rs2] && rs2 != 0);
`ifdef WB_BYPASS_EN
      chk("fwd_rs1_hit", fwd_rs1_hit, m_we && m_rd == rs1 && rs1 != 0);
      chk("fwd_rs2_hit", fwd_rs2_hit, m_we && m_rd == rs2 && rs2 != 0);
      chk("fwd_rs1_data", fwd_rs1_data, m_data);
      chk("fwd_rs2_data", fwd_rs2_data, m_data);
`endif
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int sent, budget;

      // Reset with a load presented: nothing may enter or leave.
      rst_n = 0; ld_valid = 1; ld_rd = 3; ld_data = 32'hAAAA_0003; rs1 = 3;
      cyc(3);
      chk("rst_wb_we", wb_we, 0);
      chk("rst_ld_ready", ld_ready, 1);
      chk("rst_hazard", hazard_rs1, 0);
      rst_n = 1; ld_valid = 0;
      cyc(2);
      chk("post_rst_wb_we", wb_we, 0);

      // ALU write, then an x0 write that must be dropped.
      alu_we = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
      cyc();
      chk("alu_we", wb_we, 1);
      chk("alu_rd", wb_rd, 5);
      chk("alu_data", wb_data, 32'hDEAD_BEEF);
      alu_rd = 0; alu_data = 32'h1111_1111;
      cyc();
      chk("alu_x0_we", wb_we, 0);
      chk("alu_x0_hold", wb_data, 32'hDEAD_BEEF);
      alu_we = 0;

      // Load round-trip to x7.
      ld_issue = 1; ld_issue_rd = 7; rs1 = 7;
      cyc();
      chk("ld7_hazard", hazard_rs1, 1);
      chk("ld7_reissue_ok", ld_issue_ok, 0);
      ld_issue = 0;
      ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
      cyc();
      ld_valid = 0;
      chk("ld7_lat1_we", wb_we, 0);
      chk("ld7_still_pend", hazard_rs1, 1);
      cyc();
      chk("ld7_we", wb_we, 1);
      chk("ld7_rd", wb_rd, 7);
      chk("ld7_data", wb_data, 32'h1234);
      chk("ld7_cleared", hazard_rs1, 0);

      // Collision: ALU busy 6 cycles while 4 loads return.
      for (int i = 0; i < 4; i++) begin
         ld_issue = 1; ld_issue_rd = 5'(10 + i);
         cyc();
      end
      ld_issue = 0; rs1 = 10; rs2 = 13;
      alu_we = 1; alu_rd = 20;
      for (int i = 0; i < 6; i++) begin
         alu_data = 32'h2000 + i;
         ld_valid = (i < 4); ld_rd = 5'(10 + i); ld_data = 32'hA0 + i;
         cyc();
         if (i == 3) chk("coll_full", ld_ready, 0);
      end
      ld_valid = 0; alu_we = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("coll_rd", wb_rd, 10 + i);
         chk("coll_data", wb_data, 32'hA0 + i);
      end
      cyc();
      chk("coll_drained", wb_we, 0);

      // Wrap-around: 3*DEPTH returns with random gaps and ALU back-pressure.
      sent = 0; budget = 0;
      while (sent < 3 * DEPTH && budget < 500) begin
         budget++;
         alu_we = ($urandom_range(0, 2) == 0); alu_rd = 25; alu_data = $urandom;
         ld_valid = 0;
         if (ld_ready && $urandom_range(0, 2) != 0) begin
            ld_valid = 1;
            ld_rd = (sent % 5 == 4) ? 5'd0 : 5'(1 + sent);
            ld_data = 32'hC000 + sent;
            sent++;
         end
         cyc();
      end
      chk("wrap_sent", sent, 3 * DEPTH);
      ld_valid = 0; alu_we = 0;
      cyc(DEPTH + 3);
      chk("wrap_drained", wb_we, 0);

      // Reset mid-operation discards the buffered load and its pend bit.
      alu_we = 1; alu_rd = 22; ld_issue = 1; ld_issue_rd = 15; rs1 = 15;
      cyc();
      ld_issue = 0; ld_valid = 1; ld_rd = 15; ld_data = 32'h5555;
      cyc();
      ld_valid = 0; rst_n = 0;
      cyc();
      rst_n = 1; alu_we = 0;
      cyc();
      chk("mid_rst_hazard", hazard_rs1, 0);
      chk("mid_rst_we", wb_we, 0);
      cyc();
      chk("mid_rst_no_late", wb_we, 0);

`ifdef WB_BYPASS_EN
      alu_we = 1; alu_rd = 9; alu_data = 32'h0909_0909; rs2 = 9;
      cyc();
      alu_we = 0;
      chk("byp_hit", fwd_rs2_hit, 1);
      chk("byp_data", fwd_rs2_data, 32'h0909_0909);
      rs2 = 0;
      #1;
      chk("byp_x0", fwd_rs2_hit, 0);
      cyc();
`endif

      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
